// File: rtl/tick_counter_pkg.sv
// tick_counter_pkg
// Shared types and helpers for the tick_counter block.
//   state_t : control FSM encoding (IDLE / RUN / HOLD)
//   clamp() : limits a load value to the largest legal count
package tick_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  // Returns value, or limit when value exceeds it. Operands are 32 bits
  // wide so the helper works for any counter width up to 32.
  function automatic logic [31:0] clamp(input logic [31:0] value,
                                        input logic [31:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// tick_edge_detect
// Turns the divider's slow square wave into a one-cycle rise strobe in the
// clk_in domain.
//   clk_in  : system clock (rising edge)
//   rst_n   : asynchronous active-low reset
//   tick_in : divided clock level, treated as data
//   rise    : high for one cycle after tick_in is seen going 0 -> 1
// Build option: TICK_COUNTER_SYNC_EN adds a two-flop synchronizer
// (sync1 -> tick_q) in front of the edge detector for tick_in sources that
// are not derived from clk_in. This adds one cycle of latency.
module tick_edge_detect (
  input  logic clk_in,
  input  logic rst_n,
  input  logic tick_in,
  output logic rise
);

  logic tick_q;
  logic tick_prev;

`ifdef TICK_COUNTER_SYNC_EN
  logic sync1;

  // sync1 may go metastable; tick_q is the first flop trusted downstream.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      tick_q    <= 1'b0;
      tick_prev <= 1'b0;
    end else begin
      sync1     <= tick_in;
      tick_q    <= sync1;
      tick_prev <= tick_q;
    end
  end
`else
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tick_q    <= 1'b0;
      tick_prev <= 1'b0;
    end else begin
      tick_q    <= tick_in;
      tick_prev <= tick_q;
    end
  end
`endif

  assign rise = tick_q & ~tick_prev;

endmodule

// File: rtl/tick_counter.sv
// tick_counter
// Modulo up/down event counter for rising edges of the clock divider output,
// gated by an IDLE/RUN/HOLD control FSM.
//   clk_in      : system clock (rising edge)
//   rst_n       : asynchronous active-low reset
//   tick_in     : divided clock level from the divider
//   start       : run request
//   stop        : hold request in RUN; clear-to-IDLE request in HOLD
//   load        : synchronous load strobe (any state, beats counting)
//   load_value  : value to load, clamped to MODULUS-1
//   up_dn       : 1 = count up, 0 = count down
//   clr_wrapped : clears the sticky wrap flag
//   count       : current count, always 0..MODULUS-1
//   tc_pulse    : one-cycle pulse in the cycle count shows a wrapped value
//   running     : high while the FSM is in RUN
//   wrapped     : sticky flag, set by any wrap
// Build option: TICK_COUNTER_SYNC_EN (see tick_edge_detect) adds an input
// synchronizer for tick_in.
module tick_counter #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 10
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_dn,
  input  logic             clr_wrapped,
  output logic [WIDTH-1:0] count,
  output logic             tc_pulse,
  output logic             running,
  output logic             wrapped
);

  import tick_counter_pkg::*;

  // Done at WIDTH bits so MODULUS = 2^WIDTH gives an all-ones maximum.
  localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MODULUS - 1);

  state_t           state;
  state_t           state_next;
  logic             rise;
  logic [WIDTH-1:0] count_next;
  logic             wrap_event;

  tick_edge_detect u_edge (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .tick_in (tick_in),
    .rise    (rise)
  );

  // Control FSM next state; stop takes priority over start everywhere.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !stop) state_next = RUN;
      RUN:     if (stop)           state_next = HOLD;
      HOLD: begin
        if (stop)       state_next = IDLE;
        else if (start) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Count next value. Priority: load, then the HOLD->IDLE clear, then a
  // counted rise. Only a counted rise can produce a wrap.
  always_comb begin
    count_next = count;
    wrap_event = 1'b0;
    if (load) begin
      count_next = WIDTH'(clamp(32'(load_value), 32'(MODULUS - 1)));
    end else if (state == HOLD && stop) begin
      count_next = '0;
    end else if (state == RUN && rise) begin
      if (up_dn) begin
        if (count == COUNT_MAX) begin
          count_next = '0;
          wrap_event = 1'b1;
        end else begin
          count_next = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          count_next = COUNT_MAX;
          wrap_event = 1'b1;
        end else begin
          count_next = count - WIDTH'(1);
        end
      end
    end
  end

  // Registered state and outputs; a wrap beats a same-cycle clr_wrapped.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      tc_pulse <= 1'b0;
      running  <= 1'b0;
      wrapped  <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      tc_pulse <= wrap_event;
      running  <= (state_next == RUN);
      if (wrap_event)       wrapped <= 1'b1;
      else if (clr_wrapped) wrapped <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tick_counter.sv
// tb_tick_counter
// Directed self-checking bench for tick_counter (WIDTH=8, MODULUS=10).
// Honours TICK_COUNTER_SYNC_EN for the expected tick latency.
module tb_tick_counter;

`ifdef TICK_COUNTER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'd0;
  logic       up_dn = 1'b1;
  logic       clr_wrapped = 1'b0;
  logic [7:0] count;
  logic       tc_pulse;
  logic       running;
  logic       wrapped;

  int         checks = 0;
  int         failures = 0;
  int         tc_seen = 0;
  logic [7:0] tc_count_val = 8'd0;

  tick_counter #(.WIDTH(8), .MODULUS(10)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .tick_in     (tick_in),
    .start       (start),
    .stop        (stop),
    .load        (load),
    .load_value  (load_value),
    .up_dn       (up_dn),
    .clr_wrapped (clr_wrapped),
    .count       (count),
    .tc_pulse    (tc_pulse),
    .running     (running),
    .wrapped     (wrapped)
  );

  always #5 clk_in = ~clk_in;

  // One clock, then sample 1 ns after the edge; tallies tc_pulse cycles.
  task automatic step();
    @(posedge clk_in);
    #1;
    if (tc_pulse === 1'b1) begin
      tc_seen++;
      tc_count_val = count;
    end
  endtask

  task automatic tick_period();
    tick_in = 1'b1;
    repeat (8) step();
    tick_in = 1'b0;
    repeat (8) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v);
    load_value = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (count !== 8'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    checks++; if (tc_pulse !== 1'b0) begin failures++; $display("[TB] FAIL reset_tc: got %b expected 0", tc_pulse); end
    checks++; if (running !== 1'b0) begin failures++; $display("[TB] FAIL reset_running: got %b expected 0", running); end
    checks++; if (wrapped !== 1'b0) begin failures++; $display("[TB] FAIL reset_wrapped: got %b expected 0", wrapped); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_count_up();
    up_dn = 1'b1;
    pulse_start();
    checks++; if (running !== 1'b1) begin failures++; $display("[TB] FAIL start_running: got %b expected 1", running); end
    tc_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick_period();
      checks++;
      if (count !== 8'((i + 1) % 10)) begin
        failures++;
        $display("[TB] FAIL up_count[%0d]: got %0d expected %0d", i, count, (i + 1) % 10);
      end
    end
    checks++; if (tc_seen != 1) begin failures++; $display("[TB] FAIL up_tc_cycles: got %0d expected 1", tc_seen); end
    checks++; if (tc_count_val !== 8'd0) begin failures++; $display("[TB] FAIL up_tc_at: got %0d expected 0", tc_count_val); end
    checks++; if (wrapped !== 1'b1) begin failures++; $display("[TB] FAIL up_wrapped: got %b expected 1", wrapped); end
  endtask

  task automatic test_count_down();
    up_dn = 1'b0;
    tc_seen = 0;
    do_load(8'd0);
    tick_period();
    checks++; if (count !== 8'd9) begin failures++; $display("[TB] FAIL down_wrap_count: got %0d expected 9", count); end
    checks++; if (tc_seen != 1) begin failures++; $display("[TB] FAIL down_tc_cycles: got %0d expected 1", tc_seen); end
    clr_wrapped = 1'b1;
    step();
    clr_wrapped = 1'b0;
    checks++; if (wrapped !== 1'b0) begin failures++; $display("[TB] FAIL clr_wrapped: got %b expected 0", wrapped); end
    do_load(8'd0);
    tick_in = 1'b1;
    repeat (LAT - 1) step();
    clr_wrapped = 1'b1;
    step();
    clr_wrapped = 1'b0;
    checks++; if (count !== 8'd9) begin failures++; $display("[TB] FAIL down_wrap2_count: got %0d expected 9", count); end
    checks++; if (tc_pulse !== 1'b1) begin failures++; $display("[TB] FAIL down_wrap2_tc: got %b expected 1", tc_pulse); end
    checks++; if (wrapped !== 1'b1) begin failures++; $display("[TB] FAIL set_beats_clr: got %b expected 1", wrapped); end
    step();
    checks++; if (tc_pulse !== 1'b0) begin failures++; $display("[TB] FAIL tc_one_cycle: got %b expected 0", tc_pulse); end
    repeat (5) step();
    tick_in = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_load();
    up_dn = 1'b1;
    tc_seen = 0;
    do_load(8'd15);
    checks++; if (count !== 8'd9) begin failures++; $display("[TB] FAIL load_clamp: got %0d expected 9", count); end
    checks++; if (tc_pulse !== 1'b0) begin failures++; $display("[TB] FAIL load_no_tc: got %b expected 0", tc_pulse); end
    tick_in = 1'b1;
    repeat (LAT - 1) step();
    load_value = 8'd4;
    load = 1'b1;
    step();
    load = 1'b0;
    checks++; if (count !== 8'd4) begin failures++; $display("[TB] FAIL load_beats_rise: got %0d expected 4", count); end
    repeat (6) step();
    tick_in = 1'b0;
    repeat (8) step();
    checks++; if (count !== 8'd4) begin failures++; $display("[TB] FAIL load_hold_val: got %0d expected 4", count); end
    checks++; if (tc_seen != 0) begin failures++; $display("[TB] FAIL load_tc_cycles: got %0d expected 0", tc_seen); end
  endtask

  task automatic test_hold();
    pulse_stop();
    checks++; if (running !== 1'b0) begin failures++; $display("[TB] FAIL hold_running: got %b expected 0", running); end
    tick_period();
    checks++; if (count !== 8'd4) begin failures++; $display("[TB] FAIL hold_ignores: got %0d expected 4", count); end
    pulse_start();
    checks++; if (running !== 1'b1) begin failures++; $display("[TB] FAIL resume_running: got %b expected 1", running); end
    tick_period();
    checks++; if (count !== 8'd5) begin failures++; $display("[TB] FAIL resume_count: got %0d expected 5", count); end
    pulse_stop();
    pulse_stop();
    checks++; if (count !== 8'd0) begin failures++; $display("[TB] FAIL stop_stop_count: got %0d expected 0", count); end
    checks++; if (running !== 1'b0) begin failures++; $display("[TB] FAIL stop_stop_running: got %b expected 0", running); end
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    checks++; if (running !== 1'b0) begin failures++; $display("[TB] FAIL start_stop_idle: got %b expected 0", running); end
    tick_period();
    checks++; if (count !== 8'd0) begin failures++; $display("[TB] FAIL idle_ignores: got %0d expected 0", count); end
  endtask

  task automatic test_latency();
    int edges;
    bit seen;
    pulse_start();
    edges = 0;
    seen = 1'b0;
    tick_in = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      edges++;
      if (count !== 8'd0) seen = 1'b1;
    end
    checks++;
    if (!seen || edges != LAT) begin
      failures++;
      $display("[TB] FAIL tick_latency: got %0d edges (changed=%0b) expected %0d", edges, seen, LAT);
    end
    repeat (6) step();
    tick_in = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 8'd0) begin failures++; $display("[TB] FAIL async_count: got %0d expected 0", count); end
    checks++; if (running !== 1'b0) begin failures++; $display("[TB] FAIL async_running: got %b expected 0", running); end
    checks++; if (wrapped !== 1'b0) begin failures++; $display("[TB] FAIL async_wrapped: got %b expected 0", wrapped); end
    checks++; if (tc_pulse !== 1'b0) begin failures++; $display("[TB] FAIL async_tc: got %b expected 0", tc_pulse); end
    tick_in = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (4) step();
    checks++; if (count !== 8'd0) begin failures++; $display("[TB] FAIL release_idle_count: got %0d expected 0", count); end
    pulse_start();
    repeat (6) step();
    checks++; if (count !== 8'd0) begin failures++; $display("[TB] FAIL no_stale_rise: got %0d expected 0", count); end
    tick_in = 1'b0;
    repeat (8) step();
    tick_in = 1'b1;
    repeat (8) step();
    checks++; if (count !== 8'd1) begin failures++; $display("[TB] FAIL new_rise_count: got %0d expected 1", count); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_hold();
    test_latency();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
